// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto a single-ported block memory.
// Round-robin grant, registered memory command, one-cycle done pulses.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [13:0] i_addr,
  output logic        i_done,
  output logic [63:0] i_rd_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [13:0] d_addr,
  input  logic [63:0] d_wr_data,
  output logic        d_done,
  output logic [63:0] d_rd_data,
  output logic [13:0] m_addr,
  output logic        m_re,
  output logic        m_we,
  output logic [63:0] m_wr_data,
  input  logic [63:0] m_rd_data,
  input  logic        m_rdy,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;

  state_t state, state_nxt;
  logic   last_d;
  logic   i_elig, d_elig;
  logic   grant, complete, re_nxt, we_nxt;

  // A requester whose done pulse is high this cycle is not eligible, so a
  // req dropped on the done cycle can never be re-granted.
  assign i_elig = i_req & ~i_done;
  assign d_elig = d_req & ~d_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_elig && (!d_elig || last_d)) state_nxt = I_RD;
        else if (d_elig)                   state_nxt = d_we ? D_WR : D_RD;
      end
      I_RD, D_RD, D_WR: if (m_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    grant    = (state == IDLE) && (state_nxt != IDLE);
    complete = (state != IDLE) && m_rdy;
    re_nxt   = (state_nxt == I_RD) || (state_nxt == D_RD);
    we_nxt   = (state_nxt == D_WR);
  end

  // Memory command is registered from the next state so m_re/m_we are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_re      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wr_data <= '0;
      last_d    <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rd_data <= '0;
      d_rd_data <= '0;
    end else begin
      m_re   <= re_nxt;
      m_we   <= we_nxt;
      i_done <= complete && (state == I_RD);
      d_done <= complete && ((state == D_RD) || (state == D_WR));
      if (grant) begin
        m_addr <= (state_nxt == I_RD) ? i_addr : d_addr;
        last_d <= (state_nxt != I_RD);
        if (state_nxt == D_WR) m_wr_data <= d_wr_data;
      end
      if (complete && (state == I_RD)) i_rd_data <= m_rd_data;
      if (complete && (state == D_RD)) d_rd_data <= m_rd_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a transaction-level
// reference model and a variable-latency memory responder.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, m_rdy, m_re, m_we, i_done, d_done, busy;
  logic [13:0] i_addr, d_addr, m_addr;
  logic [63:0] d_wr_data, m_wr_data, m_rd_data, i_rd_data, d_rd_data;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rd_data(i_rd_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wr_data(d_wr_data),
    .d_done(d_done), .d_rd_data(d_rd_data),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wr_data(m_wr_data),
    .m_rd_data(m_rd_data), .m_rdy(m_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [13:0] addr;
    logic [63:0] wdata;
  } gnt_t;

  gnt_t        gq[$];
  bit          dq[$];
  logic [13:0] glog[$];

  // Reference model: owner of the memory, round-robin pointer, expected registers.
  bit          own_valid, last_d, exp_i_done, exp_d_done;
  gnt_t        cur;
  logic [13:0] exp_addr;
  logic [63:0] exp_wdata, exp_i_rd, exp_d_rd;

  logic        s_i_req, s_d_req, s_d_we, s_m_rdy;
  logic [13:0] s_i_addr, s_d_addr;
  logic [63:0] s_d_wdata, s_m_rd_data;

  int mem_lat = 0;
  int mem_cnt = 0;
  bit mem_act = 0;
  bit spur    = 0;
  bit prev_act = 0;

  task automatic model_reset();
    own_valid = 0; last_d = 0; exp_i_done = 0; exp_d_done = 0;
    cur = '0; exp_addr = '0; exp_wdata = '0; exp_i_rd = '0; exp_d_rd = '0;
    gq.delete(); dq.delete();
  endtask

  initial model_reset();
  always @(negedge rst_n) model_reset();

  initial forever begin
    @(negedge clk);
    s_i_req = i_req; s_i_addr = i_addr; s_d_req = d_req; s_d_we = d_we;
    s_d_addr = d_addr; s_d_wdata = d_wr_data; s_m_rdy = m_rdy; s_m_rd_data = m_rd_data;
  end

  initial forever begin
    bit ie, de, gd, ni, nd;
    @(posedge clk);
    if (rst_n) begin
      ni = 0; nd = 0;
      if (own_valid) begin
        if (s_m_rdy) begin
          dq.push_back(cur.is_d);
          if (!cur.is_d) begin ni = 1; exp_i_rd = s_m_rd_data; end
          else begin nd = 1; if (!cur.we) exp_d_rd = s_m_rd_data; end
          own_valid = 0;
        end
      end else begin
        ie = s_i_req && !exp_i_done;
        de = s_d_req && !exp_d_done;
        if (ie || de) begin
          gd = de && (!ie || !last_d);
          cur.is_d = gd;
          cur.we   = gd && s_d_we;
          cur.addr = gd ? s_d_addr : s_i_addr;
          if (cur.we) exp_wdata = s_d_wdata;
          cur.wdata = exp_wdata;
          exp_addr  = cur.addr;
          last_d    = gd;
          own_valid = 1;
          gq.push_back(cur);
        end
      end
      exp_i_done = ni;
      exp_d_done = nd;
    end
  end

  // Monitor: pops scoreboard entries and checks all outputs every cycle.
  initial forever begin
    gnt_t g;
    bit   e;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_ctrl", {busy, m_re, m_we, i_done, d_done}, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wr_data", m_wr_data, 0);
      chk("rst_i_rd_data", i_rd_data, 0);
      chk("rst_d_rd_data", d_rd_data, 0);
      prev_act = 0;
    end else begin
      if (gq.size() > 0) begin
        g = gq.pop_front();
        chk("grant_active", m_re | m_we, 1);
        chk("grant_addr", m_addr, g.addr);
        chk("grant_we", m_we, g.we);
        if (g.we) chk("grant_wdata", m_wr_data, g.wdata);
      end
      if (dq.size() > 0) begin
        e = dq.pop_front();
        chk("done_pulse", {i_done, d_done}, e ? 2'b01 : 2'b10);
      end else begin
        chk("no_done", {i_done, d_done}, 0);
      end
      chk("busy", busy, own_valid);
      chk("m_re", m_re, own_valid && !cur.we);
      chk("m_we", m_we, own_valid && cur.we);
      chk("m_addr", m_addr, exp_addr);
      chk("m_wr_data", m_wr_data, exp_wdata);
      chk("i_rd_data", i_rd_data, exp_i_rd);
      chk("d_rd_data", d_rd_data, exp_d_rd);
      if ((m_re || m_we) && !prev_act) glog.push_back(m_addr);
      prev_act = m_re || m_we;
    end
  end

  // Memory responder: m_rdy after mem_lat cycles of command (random if 0).
  initial begin
    m_rdy = 0; m_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (m_rdy) begin m_rdy = 0; mem_act = 0; end
      if (!mem_act && (m_re || m_we)) begin
        mem_act = 1;
        mem_cnt = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 5));
      end
      if (mem_act) begin
        mem_cnt--;
        if (mem_cnt == 0) begin m_rdy = 1; m_rd_data = {$urandom, $urandom}; end
      end else if (spur) begin
        m_rdy = 1; spur = 0; m_rd_data = {$urandom, $urandom};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt, seen, dones;
    rst_n = 0; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Single I fill, latency 4
    mem_lat = 4; i_addr = 14'h0123; i_req = 1;
    cnt = 0; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (m_re) cnt++;
      if (i_done) begin seen = 1; i_req = 0; end
    end
    chk("t1_done_seen", seen, 1);
    chk("t1_re_cycles", cnt, 4);
    repeat (3) tick();

    // Contention from reset: D first, then strict alternation
    rst_n = 0; repeat (2) tick(); rst_n = 1;
    glog.delete();
    mem_lat = 2; i_addr = 14'h00AA; d_addr = 14'h00DD; d_we = 0;
    i_req = 1; d_req = 1;
    repeat (30) tick();
    i_req = 0; d_req = 0;
    repeat (6) tick();
    chk("t2_grants", glog.size() >= 4, 1);
    if (glog.size() >= 4) begin
      chk("t2_g0", glog[0], 14'h00DD);
      chk("t2_g1", glog[1], 14'h00AA);
      chk("t2_g2", glog[2], 14'h00DD);
      chk("t2_g3", glog[3], 14'h00AA);
    end

    // D writeback with inputs changed after grant
    mem_lat = 5; d_we = 1; d_addr = 14'h3FFF; d_wr_data = 64'hDEADBEEF_CAFEF00D; d_req = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (m_we) seen = 1;
    end
    chk("t3_grant_seen", seen, 1);
    chk("t3_re_low", m_re, 0);
    d_addr = 14'h0001; d_wr_data = 64'h0; d_we = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (d_done) begin seen = 1; d_req = 0; end
    end
    chk("t3_done_seen", seen, 1);
    repeat (3) tick();

    // I request dropped one cycle after grant
    mem_lat = 3; i_addr = 14'h1555; i_req = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (m_re) seen = 1;
    end
    chk("t4_grant_seen", seen, 1);
    tick(); i_req = 0;
    dones = 0;
    repeat (12) begin tick(); if (i_done) dones++; end
    chk("t4_done_count", dones, 1);
    chk("t4_idle", busy, 0);

    // Spurious m_rdy in IDLE, then reset during D_RD
    spur = 1;
    repeat (4) tick();
    mem_lat = 6; d_we = 0; d_addr = 14'h0777; d_req = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (m_re) seen = 1;
    end
    chk("t5_grant_seen", seen, 1);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("t5_async_re", m_re, 0);
    chk("t5_async_busy", busy, 0);
    d_req = 0;
    tick(); rst_n = 1;
    dones = 0;
    repeat (10) begin tick(); if (d_done || i_done) dones++; end
    chk("t5_no_done", dones, 0);

    // Randomised traffic
    mem_lat = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!i_req) begin
        if ($urandom_range(0, 3) == 0) begin i_req = 1; i_addr = 14'($urandom); end
      end else if (i_done) begin
        if ($urandom_range(0, 1) == 1) i_req = 0; else i_addr = 14'($urandom);
      end else if ($urandom_range(0, 15) == 0) i_req = 0;
      else if ($urandom_range(0, 7) == 0) i_addr = 14'($urandom);
      if (!d_req) begin
        if ($urandom_range(0, 3) == 0) begin
          d_req = 1; d_addr = 14'($urandom); d_we = 1'($urandom);
          d_wr_data = {$urandom, $urandom};
        end
      end else if (d_done) begin
        if ($urandom_range(0, 1) == 1) d_req = 0;
        else begin d_addr = 14'($urandom); d_we = 1'($urandom); d_wr_data = {$urandom, $urandom}; end
      end else if ($urandom_range(0, 15) == 0) d_req = 0;
      else if ($urandom_range(0, 7) == 0) begin
        d_addr = 14'($urandom); d_we = 1'($urandom); d_wr_data = {$urandom, $urandom};
      end
      if (!busy && $urandom_range(0, 49) == 0) spur = 1;
    end
    i_req = 0; d_req = 0;
    repeat (20) tick();
    chk("end_gq_empty", gq.size(), 0);
    chk("end_dq_empty", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
